pwm_peripheral: RTL and testbench

- Consumes the five configuration registers written over SPI by the SPI register peripheral and drives the 16 chip outputs.
- Each output bit can be held low, held high, or driven by a shared 8-bit PWM waveform whose duty comes from pwm_duty_cycle.
- The duty value is double-buffered and updated only at a PWM period boundary, so a duty change never produces a glitch.
- Sits directly downstream of the SPI register peripheral, in the same clk domain.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_timebase.sv | 60 ++++++
 rtl/pwm_peripheral.sv | 62 ++++++
 tb/tb_pwm_peripheral.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM output peripheral.
// Holds the counter width, the "always high" duty code, the number of
// chip outputs and the default prescaler divide used by the top level.
package pwm_pkg;

  localparam int PWM_CNT_W       = 8;
  localparam int NUM_OUTPUTS     = 16;
  localparam int DEFAULT_CLK_DIV = 13;

  typedef logic [PWM_CNT_W-1:0]   pwm_cnt_t;
  typedef logic [NUM_OUTPUTS-1:0] pwm_vec_t;

  localparam pwm_cnt_t DUTY_FULL = 8'hFF;

  // Waveform level for a given count and duty. The full-scale code is
  // special-cased so that 0xFF really means "always high" rather than
  // 255/256 high.
  function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared PWM time base.
// Divides clk by CLK_DIV into count steps, runs an 8-bit PWM counter,
// holds the shadow copy of the duty value and flags each period wrap.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   duty_in     in   8  requested duty, captured only at a period wrap
//   level       out  1  combinational waveform level for this cycle
//   period_tick out  1  registered one-cycle pulse after each wrap
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     duty_in,
  output logic           level,
  output logic           period_tick
);

  // The prescaler is 8 bits wide because CLK_DIV never exceeds 255.
  localparam logic [7:0] PRESC_LAST = 8'(CLK_DIV - 1);

  logic [7:0] prescaler;
  pwm_cnt_t   pwm_cnt;
  pwm_cnt_t   duty_sh;
  logic       step;
  logic       wrap;

  // With CLK_DIV = 1 the prescaler sits at zero and step is high every
  // cycle, so the counter advances on every clk.
  assign step  = (prescaler == PRESC_LAST);
  assign wrap  = step && (pwm_cnt == {PWM_CNT_W{1'b1}});
  assign level = pwm_level(pwm_cnt, duty_sh);

  // The duty shadow only loads at the wrap, so a duty written mid-period
  // cannot cut a pulse short or stretch it. A duty presented in the same
  // cycle as the wrap is the one that gets captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= 8'd0;
      pwm_cnt     <= '0;
      duty_sh     <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= wrap;
      if (step) begin
        prescaler <= 8'd0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        prescaler <= prescaler + 8'd1;
      end
      if (wrap) begin
        duty_sh <= duty_in;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives the 16 chip outputs from the SPI configuration
// registers. Each bit is forced low, forced high, or follows the shared
// PWM waveform.
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   en_reg_out_7_0  in   8   output enable, bits 7..0
//   en_reg_out_15_8 in   8   output enable, bits 15..8
//   en_reg_pwm_7_0  in   8   PWM mode select, bits 7..0
//   en_reg_pwm_15_8 in   8   PWM mode select, bits 15..8
//   pwm_duty_cycle  in   8   requested duty (0x00 low, 0xFF high)
//   pwm_out         out  16  registered output pins
//   period_tick     out  1   one-clk pulse at each PWM period wrap
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] pwm_out,
  output logic        period_tick
);

  pwm_vec_t en_out;
  pwm_vec_t en_pwm;
  pwm_vec_t next_out;
  logic     level;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .duty_in     (pwm_duty_cycle),
    .level       (level),
    .period_tick (period_tick)
  );

  // Enabled bits in static mode are high; enabled bits in PWM mode take
  // the waveform level; disabled bits are low whatever the mode says.
  assign next_out = en_out & (~en_pwm | {NUM_OUTPUTS{level}});

  // Registering the pins keeps the outputs glitch-free and gives the
  // one-clk latency from enable/mode/count to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= next_out;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed bench for pwm_peripheral. Two instances run
// side by side from the same inputs, one with the default divide of 13 and
// one with a divide of 1. A behavioural model derives each output from the
// number of clocks elapsed since reset; a per-cycle compare process checks
// both instances against it, and the directed sequence measures pulse
// widths and period lengths against hand-computed numbers.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  pwm_duty_cycle = 8'h00;
  logic [15:0] out13, out1;
  logic        tick13, tick1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(13)) dut13 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pwm_out         (out13),
    .period_tick     (tick13)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .pwm_out         (out1),
    .period_tick     (tick1)
  );

  // Model state per instance: clocks since reset, captured duty, outputs.
  int          m_div [2] = '{13, 1};
  int          m_k   [2];
  logic [7:0]  m_duty[2];
  logic [15:0] m_out [2];
  logic        m_tick[2];
  bit          model_valid = 1'b0;

  // The counter value after k clocks is floor(k/div) mod 256, and a wrap
  // happens on the last clock of each 256*div period.
  always @(posedge clk) begin : model
    int   period;
    int   cnt;
    logic lvl;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_k[m]    = 0;
        m_duty[m] = 8'h00;
        m_out[m]  = 16'h0000;
        m_tick[m] = 1'b0;
      end else begin
        period    = 256 * m_div[m];
        cnt       = (m_k[m] / m_div[m]) % 256;
        lvl       = (m_duty[m] == 8'hFF) ? 1'b1 : (cnt < int'(m_duty[m]));
        for (int b = 0; b < 16; b++) begin
          m_out[m][b] = en_out[b] ? (en_pwm[b] ? lvl : 1'b1) : 1'b0;
        end
        m_tick[m] = ((m_k[m] % period) == period - 1);
        if (m_tick[m]) m_duty[m] = pwm_duty_cycle;
        m_k[m] = m_k[m] + 1;
      end
    end
    if (rst) model_valid = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    $display("[TB] FAIL %s: bound expired, got no period_tick, expected one", name);
  endtask

  task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
    en_out         = eo;
    en_pwm         = ep;
    pwm_duty_cycle = duty;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("pwm_out_div13", {16'h0, out13}, {16'h0, m_out[0]});
      checkOutput("tick_div13", {31'h0, tick13}, {31'h0, m_tick[0]});
      checkOutput("pwm_out_div1", {16'h0, out1}, {16'h0, m_out[1]});
      checkOutput("tick_div1", {31'h0, tick1}, {31'h0, m_tick[1]});
    end
  end

  function automatic logic tickOf(input int which);
    return (which == 0) ? tick13 : tick1;
  endfunction

  function automatic logic bitOf(input int which);
    return (which == 0) ? out13[0] : out1[0];
  endfunction

  // Advance on negedges until the chosen instance shows period_tick.
  task automatic waitTick(input int which, input string name);
    int limit = 256 * m_div[which] + 4;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tickOf(which) && n < limit);
    if (!tickOf(which)) reportTimeout(name);
  endtask

  // Starting on a tick sample, count bit0 highs (DUT and model) over the
  // samples up to and including the next tick. Optionally change the
  // duty request part-way through.
  task automatic measureWindow(input int which, input int change_at, input logic [7:0] new_duty,
                               input string name, output int high, output int model_high, output int span);
    int limit = 256 * m_div[which] + 4;
    high = 0;
    model_high = 0;
    span = 0;
    do begin
      @(negedge clk);
      span++;
      if (bitOf(which)) high++;
      if (m_out[which][0]) model_high++;
      if (span == change_at) pwm_duty_cycle = new_duty;
    end while (!tickOf(which) && span < limit);
    if (!tickOf(which)) reportTimeout(name);
  endtask

  task automatic checkWindow(input int which, input string name, input int exp_high, input int exp_span);
    int high, model_high, span;
    measureWindow(which, -1, 8'h00, name, high, model_high, span);
    checkOutput({name, "_high"}, high, exp_high);
    checkOutput({name, "_model_high"}, model_high, exp_high);
    checkOutput({name, "_span"}, span, exp_span);
  endtask

  initial begin : sequencer
    int high, model_high, span;

    // Reset held for three cycles, then static outputs.
    repeat (3) @(negedge clk);
    checkOutput("reset_out13", {16'h0, out13}, 32'h0);
    checkOutput("reset_tick13", {31'h0, tick13}, 32'h0);
    checkOutput("reset_out1", {16'h0, out1}, 32'h0);
    rst = 1'b0;
    applyStimulus(16'hA5C3, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("static_out13", {16'h0, out13}, 32'h0000A5C3);
    checkOutput("static_out1", {16'h0, out1}, 32'h0000A5C3);

    // 50% duty on bit0.
    applyStimulus(16'h0001, 16'h0001, 8'h80);
    waitTick(0, "t2_first_tick");
    checkWindow(0, "t2_win1", 1664, 3328);
    checkWindow(0, "t2_win2", 1664, 3328);

    // Duty 0x00: constant low across two periods.
    pwm_duty_cycle = 8'h00;
    waitTick(0, "t3_zero_tick");
    checkWindow(0, "t3_zero_win1", 0, 3328);
    checkWindow(0, "t3_zero_win2", 0, 3328);

    // Duty 0xFF: constant high.
    pwm_duty_cycle = 8'hFF;
    waitTick(0, "t3_full_tick");
    checkWindow(0, "t3_full_win", 3328, 3328);

    // PWM mode with the output disabled stays low.
    applyStimulus(16'h0000, 16'h0001, 8'hFF);
    repeat (20) @(negedge clk);
    checkOutput("t3_disabled13", {31'h0, out13[0]}, 32'h0);
    checkOutput("t3_disabled1", {31'h0, out1[0]}, 32'h0);

    // Duty 0x01: one count step (13 clocks) high per period.
    applyStimulus(16'h0001, 16'h0001, 8'h01);
    waitTick(0, "t3_one_tick");
    checkWindow(0, "t3_one_win", 13, 3328);

    // Duty change mid-period only takes effect from the next period.
    pwm_duty_cycle = 8'h40;
    waitTick(0, "t4_tick");
    measureWindow(0, 1664, 8'hC0, "t4_win1", high, model_high, span);
    checkOutput("t4_win1_high", high, 832);
    checkOutput("t4_win1_model_high", model_high, 832);
    checkOutput("t4_win1_span", span, 3328);
    checkWindow(0, "t4_win2", 2496, 3328);

    // Reset part-way through a period (count 0x55 = 1105 clocks in).
    pwm_duty_cycle = 8'h80;
    repeat (1105) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_out13", {16'h0, out13}, 32'h0);
    checkOutput("t5_rst_tick13", {31'h0, tick13}, 32'h0);
    checkOutput("t5_rst_out1", {16'h0, out1}, 32'h0);
    rst = 1'b0;
    checkWindow(0, "t5_after_rst", 0, 3328);

    // Divide-by-1 instance: duty 3 gives 3 high clocks per 256.
    pwm_duty_cycle = 8'h03;
    waitTick(1, "t6_tick");
    checkWindow(1, "t6_win1", 3, 256);
    checkWindow(1, "t6_win2", 3, 256);

    @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
